// File: rtl/sdram_pkg.sv
// sdram_pkg -- shared definitions for the SDRAM power-up init sequencer.
//   * SDRAM command encodings {CS_N, RAS_N, CAS_N, WE_N}
//   * sequencer state enum (EMRS states exist only when SDRAM_INIT_EMRS_EN
//     is defined)
//   * mode-register bit positions and the mode-word builder
package sdram_pkg;

    typedef logic [3:0] cmd_t;

    localparam cmd_t CMD_NOP = 4'b0111;
    localparam cmd_t CMD_PRE = 4'b0010;
    localparam cmd_t CMD_REF = 4'b0001;
    localparam cmd_t CMD_MRS = 4'b0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_PRE,
        ST_TRP_W,
        ST_REF,
        ST_TRFC_W,
        ST_MRS,
        ST_TMRD_W,
`ifdef SDRAM_INIT_EMRS_EN
        ST_EMRS,
        ST_TEMRS_W,
`endif
        ST_DONE
    } state_e;

    // Mode register layout (A[9:0]); everything above A9 is written as 0.
    localparam int MR_W      = 10;
    localparam int MR_BL_LSB = 0;   // A[2:0] burst length code
    localparam int MR_BT_BIT = 3;   // A3 burst type, 0 = sequential
    localparam int MR_CL_LSB = 4;   // A[6:4] CAS latency
    localparam int MR_WB_BIT = 9;   // A9 write-burst mode
    localparam int ADDR_AP_BIT = 10; // A10 selects "all banks" on PRECHARGE

    function automatic logic [MR_W-1:0] mode_word(input int cas_lat,
                                                  input int burst_len,
                                                  input int wb_single);
        logic [MR_W-1:0] w;
        w                  = '0;
        w[MR_BL_LSB +: 3]  = 3'($clog2(burst_len));
        w[MR_BT_BIT]       = 1'b0;
        w[MR_CL_LSB +: 3]  = 3'(cas_lat);
        w[MR_WB_BIT]       = wb_single[0];
        return w;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// sdram_init_seq_if -- control handshake between the host and the SDRAM
// init sequencer.
//   ireq  : start/restart request (level-sampled)
//   ienb  : DRAM pin-drive enable
//   obusy : sequence in progress
//   ofin  : initialisation complete
// master = sequencer side, slave = host side.
interface sdram_init_seq_if;
    logic ireq;
    logic ienb;
    logic obusy;
    logic ofin;

    modport master (input ireq, input ienb, output obusy, output ofin);
    modport slave  (output ireq, output ienb, input obusy, input ofin);
endinterface

// File: rtl/sdram_wait_cnt.sv
// sdram_wait_cnt -- loadable down-counter with terminal-count flag.
//   iclk, ctr_reset : clock, async active-high reset (count -> 0)
//   ld_i, ld_val_i  : load a new count (takes priority over counting)
//   tc_o            : count is zero
// The count stops at zero, so it can never wrap.
module sdram_wait_cnt #(
    parameter int CW = 4
) (
    input  logic          iclk,
    input  logic          ctr_reset,
    input  logic          ld_i,
    input  logic [CW-1:0] ld_val_i,
    output logic          tc_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i)
            cnt_d = ld_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) cnt_q <= '0;
        else           cnt_q <= cnt_d;
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq -- SDRAM power-up initialisation sequencer.
// Sequence: PWRUP NOPs -> PRECHARGE ALL -> N_REF x AUTO REFRESH -> LOAD MODE
// (-> LOAD EXT MODE when SDRAM_INIT_EMRS_EN is defined) -> DONE.
// Ports:
//   iclk, ctr_reset : clock, async active-high reset
//   ctl             : sdram_init_seq_if.master (ireq, ienb, obusy, ofin)
//   DRAM_*          : SDRAM command/address pins, tri-stated when ienb=0
// Outputs are decoded from the next state and registered, so the pins show
// the command of whatever state the FSM currently holds.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int ADDR_W    = 13,
    parameter int BA_W      = 2,
    parameter int DQM_W     = 2,
    parameter int T_PWRUP   = 10000,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int N_REF     = 8,
    parameter int CAS_LAT   = 2,
    parameter int BURST_LEN = 1,
    parameter int WB_SINGLE = 1
) (
    input  logic              iclk,
    input  logic              ctr_reset,
    sdram_init_seq_if.master  ctl,
    output logic              DRAM_CKE,
    output logic              DRAM_CS_N,
    output logic              DRAM_RAS_N,
    output logic              DRAM_CAS_N,
    output logic              DRAM_WE_N,
    output logic [ADDR_W-1:0] DRAM_ADDR,
    output logic [BA_W-1:0]   DRAM_BA,
    output logic [DQM_W-1:0]  DRAM_DQM
);

    // ---- parameter legality --------------------------------------------
    if (T_PWRUP < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1 || N_REF < 1) begin : g_bad_timing
        $error("sdram_init_seq: T_* and N_REF must all be >= 1");
    end
    if (CAS_LAT != 2 && CAS_LAT != 3) begin : g_bad_cl
        $error("sdram_init_seq: CAS_LAT must be 2 or 3");
    end
    if (BURST_LEN != 1 && BURST_LEN != 2 && BURST_LEN != 4 && BURST_LEN != 8) begin : g_bad_bl
        $error("sdram_init_seq: BURST_LEN must be 1, 2, 4 or 8");
    end
    if (ADDR_W <= ADDR_AP_BIT || BA_W < 2) begin : g_bad_width
        $error("sdram_init_seq: ADDR_W must cover A10 and BA_W must be >= 2");
    end

    localparam int CW = $clog2(max4(T_PWRUP, T_RP, T_RFC, T_MRD)) + 1;
    localparam int RW = $clog2(N_REF + 1);

    // A command state lasts one cycle; its wait state covers the remaining
    // T-1 cycles, so the wait counter is loaded with T-2 (skipped if T=1).
    localparam int LD_PWRUP = T_PWRUP - 1;
    localparam int LD_RP    = (T_RP  > 1) ? T_RP  - 2 : 0;
    localparam int LD_RFC   = (T_RFC > 1) ? T_RFC - 2 : 0;
    localparam int LD_MRD   = (T_MRD > 1) ? T_MRD - 2 : 0;

    localparam logic [ADDR_W-1:0] MODE_WORD =
        ADDR_W'(mode_word(CAS_LAT, BURST_LEN, WB_SINGLE));

`ifdef SDRAM_INIT_EMRS_EN
    localparam state_e AFTER_MRS = ST_EMRS;
`else
    localparam state_e AFTER_MRS = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic [RW-1:0]     ref_cnt_q, ref_cnt_d;
    logic              ld;
    logic [CW-1:0]     ld_val;
    logic              tc;

    cmd_t              cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic              cke_q, cke_d;
    logic              busy_q, busy_d;
    logic              fin_q, fin_d;

    sdram_wait_cnt #(.CW(CW)) u_wait (
        .iclk      (iclk),
        .ctr_reset (ctr_reset),
        .ld_i      (ld),
        .ld_val_i  (ld_val),
        .tc_o      (tc)
    );

    // ---- next state ----------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ld        = 1'b0;
        ld_val    = '0;
        ref_cnt_d = ref_cnt_q;

        if (state_q == ST_IDLE || state_q == ST_DONE)
            ref_cnt_d = '0;
        else if (state_q == ST_REF)
            ref_cnt_d = ref_cnt_q + RW'(1);

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ctl.ireq) begin
                    state_d = ST_PWRUP;
                    ld      = 1'b1;
                    ld_val  = CW'(LD_PWRUP);
                end
            end
            ST_PWRUP: if (tc) state_d = ST_PRE;
            ST_PRE: begin
                if (T_RP > 1) begin
                    state_d = ST_TRP_W;
                    ld      = 1'b1;
                    ld_val  = CW'(LD_RP);
                end else begin
                    state_d = ST_REF;
                end
            end
            ST_TRP_W: if (tc) state_d = ST_REF;
            ST_REF: begin
                if (T_RFC > 1) begin
                    state_d = ST_TRFC_W;
                    ld      = 1'b1;
                    ld_val  = CW'(LD_RFC);
                end else begin
                    // count not yet bumped for this refresh
                    state_d = (ref_cnt_q == RW'(N_REF - 1)) ? ST_MRS : ST_REF;
                end
            end
            ST_TRFC_W: begin
                if (tc) state_d = (ref_cnt_q == RW'(N_REF)) ? ST_MRS : ST_REF;
            end
            ST_MRS: begin
                if (T_MRD > 1) begin
                    state_d = ST_TMRD_W;
                    ld      = 1'b1;
                    ld_val  = CW'(LD_MRD);
                end else begin
                    state_d = AFTER_MRS;
                end
            end
            ST_TMRD_W: if (tc) state_d = AFTER_MRS;
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                if (T_MRD > 1) begin
                    state_d = ST_TEMRS_W;
                    ld      = 1'b1;
                    ld_val  = CW'(LD_MRD);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_TEMRS_W: if (tc) state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- output decode of the state about to be entered ---------------
    always_comb begin
        cmd_d  = CMD_NOP;
        addr_d = '0;
        ba_d   = '0;
        cke_d  = (state_d != ST_IDLE);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        fin_d  = (state_d == ST_DONE);
        case (state_d)
            ST_PRE: begin
                cmd_d               = CMD_PRE;
                addr_d[ADDR_AP_BIT] = 1'b1;
                ba_d                = '1;
            end
            ST_REF: cmd_d = CMD_REF;
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                addr_d = MODE_WORD;
            end
`ifdef SDRAM_INIT_EMRS_EN
            ST_EMRS: begin
                cmd_d = CMD_MRS;
                ba_d  = BA_W'(2'b10);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge iclk or posedge ctr_reset) begin
        if (ctr_reset) begin
            state_q   <= ST_IDLE;
            ref_cnt_q <= '0;
            cmd_q     <= CMD_NOP;
            addr_q    <= '0;
            ba_q      <= '0;
            cke_q     <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_cnt_q <= ref_cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            ba_q      <= ba_d;
            cke_q     <= cke_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
        end
    end

    assign ctl.obusy = busy_q;
    assign ctl.ofin  = fin_q;

    // ienb only gates the pins; the sequencer keeps running underneath.
    assign DRAM_CKE   = ctl.ienb ? cke_q    : 1'bz;
    assign DRAM_CS_N  = ctl.ienb ? cmd_q[3] : 1'bz;
    assign DRAM_RAS_N = ctl.ienb ? cmd_q[2] : 1'bz;
    assign DRAM_CAS_N = ctl.ienb ? cmd_q[1] : 1'bz;
    assign DRAM_WE_N  = ctl.ienb ? cmd_q[0] : 1'bz;
    assign DRAM_ADDR  = ctl.ienb ? addr_q   : {ADDR_W{1'bz}};
    assign DRAM_BA    = ctl.ienb ? ba_q     : {BA_W{1'bz}};
    assign DRAM_DQM   = ctl.ienb ? {DQM_W{1'b1}} : {DQM_W{1'bz}};

endmodule

// File: tb/tb_sdram_init_seq.sv
module tb_sdram_init_seq;

    localparam int TP    = 12;
    localparam int TRP   = 2;
    localparam int TRFC  = 4;
    localparam int TMRD  = 2;
    localparam int NREF  = 2;
`ifdef SDRAM_INIT_EMRS_EN
    localparam int EMRS = 1;
`else
    localparam int EMRS = 0;
`endif
    // Schedule positions, cycle 0 = first power-up cycle.
    localparam int P_PRE  = TP;
    localparam int P_REF0 = TP + TRP;
    localparam int P_MRS  = P_REF0 + NREF * TRFC;
    localparam int P_EMRS = P_MRS + TMRD;
    localparam int P_DONE = P_MRS + TMRD * (1 + EMRS);

    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic        cke;
        logic        busy;
        logic        fin;
    } exp_t;

    logic iclk = 1'b0;
    logic rst  = 1'b1;
    logic ireq = 1'b0;
    logic ienb = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   mk = -1;   // model position: -1 idle, 0..P_DONE-1 running, P_DONE done

    always #5 iclk = ~iclk;

    sdram_init_seq_if ctl();
    sdram_init_seq_if ctl2();
    assign ctl.ireq  = ireq;
    assign ctl.ienb  = ienb;
    assign ctl2.ireq = ireq;
    assign ctl2.ienb = ienb;

    wire        cke1, cs1, ras1, cas1, we1;
    wire [12:0] addr1;
    wire [1:0]  ba1, dqm1;
    wire        cke2, cs2, ras2, cas2, we2;
    wire [12:0] addr2;
    wire [1:0]  ba2, dqm2;
    wire [3:0]  cmd1 = {cs1, ras1, cas1, we1};
    wire [3:0]  cmd2 = {cs2, ras2, cas2, we2};

    sdram_init_seq #(.T_PWRUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .N_REF(NREF)) dut (
        .iclk(iclk), .ctr_reset(rst), .ctl(ctl),
        .DRAM_CKE(cke1), .DRAM_CS_N(cs1), .DRAM_RAS_N(ras1), .DRAM_CAS_N(cas1),
        .DRAM_WE_N(we1), .DRAM_ADDR(addr1), .DRAM_BA(ba1), .DRAM_DQM(dqm1)
    );

    sdram_init_seq #(.T_PWRUP(TP), .T_RP(TRP), .T_RFC(TRFC), .T_MRD(TMRD), .N_REF(NREF),
                     .CAS_LAT(3), .BURST_LEN(8), .WB_SINGLE(0)) dut2 (
        .iclk(iclk), .ctr_reset(rst), .ctl(ctl2),
        .DRAM_CKE(cke2), .DRAM_CS_N(cs2), .DRAM_RAS_N(ras2), .DRAM_CAS_N(cas2),
        .DRAM_WE_N(we2), .DRAM_ADDR(addr2), .DRAM_BA(ba2), .DRAM_DQM(dqm2)
    );

    // Mode word built from the mode-register field definitions.
    localparam logic [12:0] MW1 = 13'((0 << 0) | (2 << 4) | (1 << 9));

    function automatic exp_t model_out(input int k, input logic [12:0] mw);
        exp_t e;
        e.cmd  = 4'b0111;
        e.addr = '0;
        e.ba   = '0;
        e.cke  = (k >= 0);
        e.busy = (k >= 0) && (k < P_DONE);
        e.fin  = (k == P_DONE);
        if (k == P_PRE) begin
            e.cmd = 4'b0010; e.addr = 13'h400; e.ba = 2'b11;
        end else if (k >= P_REF0 && k < P_MRS && ((k - P_REF0) % TRFC) == 0) begin
            e.cmd = 4'b0001;
        end else if (k == P_MRS) begin
            e.cmd = 4'b0000; e.addr = mw;
        end else if (EMRS == 1 && k == P_EMRS) begin
            e.cmd = 4'b0000; e.ba = 2'b10;
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    // Pin must not be showing the value it would be driven with.
    task automatic undrv(input string nm, input logic [31:0] act, input logic [31:0] drv);
        checks++;
        if (act === drv) begin
            errors++;
            $display("FAIL %s: got driven value %0h expected undriven at t=%0t", nm, act, $time);
        end
    endtask

    task automatic chk_dut(input string tg, input logic [3:0] cmd, input logic [12:0] addr,
                           input logic [1:0] ba, input logic cke, input logic [1:0] dqm,
                           input logic busy, input logic fin, input exp_t e);
        chk({tg, "_busy"}, 32'(busy), 32'(e.busy));
        chk({tg, "_fin"},  32'(fin),  32'(e.fin));
        if (ienb) begin
            chk({tg, "_cmd"},  32'(cmd),  32'(e.cmd));
            chk({tg, "_addr"}, 32'(addr), 32'(e.addr));
            chk({tg, "_ba"},   32'(ba),   32'(e.ba));
            chk({tg, "_cke"},  32'(cke),  32'(e.cke));
            chk({tg, "_dqm"},  32'(dqm),  32'h3);
        end else begin
            undrv({tg, "_cke_z"}, 32'(cke), 32'h1);
            undrv({tg, "_dqm_z"}, 32'(dqm), 32'h3);
        end
    endtask

    always @(posedge iclk or posedge rst) begin
        if (rst)                          mk <= -1;
        else if (mk == -1 || mk == P_DONE) begin
            if (ireq) mk <= 0;
        end else                          mk <= mk + 1;
    end

    always @(negedge iclk) begin
        chk_dut("d1", cmd1, addr1, ba1, cke1, dqm1, ctl.obusy,  ctl.ofin,  model_out(mk, MW1));
        chk_dut("d2", cmd2, addr2, ba2, cke2, dqm2, ctl2.obusy, ctl2.ofin, model_out(mk, 13'h033));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iclk);
            #2;
        end
    endtask

    // Single ireq pulse with literal timeline checks.
    task automatic run_basic(input string tg);
        ireq = 1'b1; tick(1); ireq = 1'b0;
        chk({tg, "_c0_busy"}, 32'(ctl.obusy), 32'h1);
        chk({tg, "_c0_cke"},  32'(cke1), 32'h1);
        chk({tg, "_c0_cmd"},  32'(cmd1), 32'h7);
        tick(11);
        chk({tg, "_c11_cmd"}, 32'(cmd1), 32'h7);
        tick(1);
        chk({tg, "_c12_cmd"}, 32'(cmd1), 32'h2);
        chk({tg, "_c12_addr"}, 32'(addr1), 32'h400);
        chk({tg, "_c12_ba"},  32'(ba1), 32'h3);
        tick(2);
        chk({tg, "_c14_cmd"}, 32'(cmd1), 32'h1);
        tick(4);
        chk({tg, "_c18_cmd"}, 32'(cmd1), 32'h1);
        tick(4);
        chk({tg, "_c22_cmd"},   32'(cmd1), 32'h0);
        chk({tg, "_c22_addr"},  32'(addr1), 32'h220);
        chk({tg, "_c22_ba"},    32'(ba1), 32'h0);
        chk({tg, "_c22_addr2"}, 32'(addr2), 32'h033);
        tick(2);
`ifdef SDRAM_INIT_EMRS_EN
        chk({tg, "_c24_cmd"},  32'(cmd1), 32'h0);
        chk({tg, "_c24_ba"},   32'(ba1), 32'h2);
        chk({tg, "_c24_addr"}, 32'(addr1), 32'h0);
        tick(2);
`endif
        chk({tg, "_done_fin"},  32'(ctl.ofin), 32'h1);
        chk({tg, "_done_busy"}, 32'(ctl.obusy), 32'h0);
        tick(3);
        chk({tg, "_fin_hold"}, 32'(ctl.ofin), 32'h1);
    endtask

    initial begin
        tick(2);
        chk("rst_cke",  32'(cke1), 32'h0);
        chk("rst_cmd",  32'(cmd1), 32'h7);
        chk("rst_addr", 32'(addr1), 32'h0);
        chk("rst_dqm",  32'(dqm1), 32'h3);
        chk("rst_busy", 32'(ctl.obusy), 32'h0);
        chk("rst_fin",  32'(ctl.ofin), 32'h0);
        rst = 1'b0;
        tick(3);
        chk("idle_cke", 32'(cke1), 32'h0);

        run_basic("basic");

        // reset in the middle of the refresh phase
        ireq = 1'b1; tick(1); ireq = 1'b0;
        tick(16);
        rst = 1'b1; #1;
        chk("midrst_cke",  32'(cke1), 32'h0);
        chk("midrst_cmd",  32'(cmd1), 32'h7);
        chk("midrst_busy", 32'(ctl.obusy), 32'h0);
        chk("midrst_fin",  32'(ctl.ofin), 32'h0);
        tick(2); rst = 1'b0; tick(2);
        chk("postrst_idle", 32'(ctl.obusy), 32'h0);
        run_basic("replay");

        // ireq held through the whole sequence
        ireq = 1'b1; tick(1);
        tick(20);
        chk("held_c20_busy", 32'(ctl.obusy), 32'h1);
        chk("held_c20_fin",  32'(ctl.ofin), 32'h0);
        tick(P_DONE - 20);
        chk("held_done_fin", 32'(ctl.ofin), 32'h1);
        tick(1);
        chk("restart_fin",  32'(ctl.ofin), 32'h0);
        chk("restart_busy", 32'(ctl.obusy), 32'h1);
        chk("restart_cmd",  32'(cmd1), 32'h7);
        ireq = 1'b0;
        tick(P_DONE);
        chk("restart_done", 32'(ctl.ofin), 32'h1);

        // pins released during cycles 10..20
        tick(2);
        ireq = 1'b1; tick(1); ireq = 1'b0;
        tick(10); ienb = 1'b0; #1;
        undrv("ienb_c10_cke", 32'(cke1), 32'h1);
        tick(2);
        undrv("ienb_c12_dqm", 32'(dqm1), 32'h3);
        chk("ienb_c12_busy", 32'(ctl.obusy), 32'h1);
        tick(9); ienb = 1'b1; #1;
        chk("ienb_c21_cke", 32'(cke1), 32'h1);
        tick(P_DONE - 21);
        chk("ienb_done_fin", 32'(ctl.ofin), 32'h1);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
